blit_addrgen_pipe: RTL and testbench

BLIT_ADDRGEN_PIPE -- requirements
Module: blit_addrgen_pipe

---
 rtl/blit_addrgen_pipe_if.sv | 46 ++++
 rtl/blit_addrgen_pipe.sv | 181 ++++++++++++++++++
 tb/tb_blit_addrgen_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_addrgen_pipe_if.sv
// ---------------------------------------------------------------------------
// blit_addrgen_pipe_if
// Pixel request/response bundle for the blitter address generator.
//   Request side : in_valid/in_ready handshake, destination and source
//                  coordinates, draw/textmode flags and pixel size.
//   Response side: out_valid/out_ready handshake, source/destination byte
//                  addresses, glyph bit index, write enable and byte enables.
// The master modport belongs to the pixel producer (and response consumer);
// the slave modport belongs to the address generator.
// ---------------------------------------------------------------------------
interface blit_addrgen_pipe_if #(
  parameter int ADDR_W  = 26,
  parameter int COORD_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_dest_x;
  logic [COORD_W-1:0] in_dest_y;
  logic [COORD_W-1:0] in_src_x;
  logic [COORD_W-1:0] in_src_y;
  logic               in_draw;
  logic               in_textmode;
  logic [1:0]         in_pix_size;

  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_src_addr;
  logic [ADDR_W-1:0]  out_dest_addr;
  logic [2:0]         out_src_bit;
  logic               out_write_en;
  logic [3:0]         out_byte_en;

  modport master (
    output in_valid, in_dest_x, in_dest_y, in_src_x, in_src_y,
           in_draw, in_textmode, in_pix_size, out_ready,
    input  in_ready, out_valid, out_src_addr, out_dest_addr,
           out_src_bit, out_write_en, out_byte_en
  );

  modport slave (
    input  in_valid, in_dest_x, in_dest_y, in_src_x, in_src_y,
           in_draw, in_textmode, in_pix_size, out_ready,
    output in_ready, out_valid, out_src_addr, out_dest_addr,
           out_src_bit, out_write_en, out_byte_en
  );
endinterface

// File: rtl/blit_addrgen_pipe.sv
// ---------------------------------------------------------------------------
// blit_addrgen_pipe
// Two-stage pixel address generator for a blitter.
//   S1: row products (y * bytes-per-row), scaled x offsets, clip test.
//   S2: address sums, pixel-size alignment, byte enables; S2 is the output
//       register set.
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   pix                  request/response bundle (slave side)
//   src_base, dest_base  surface base byte addresses (quasi-static)
//   src_bpr, dest_bpr    bytes per row (quasi-static)
//   clip_x1..clip_y2     clip window, x1/y1 inclusive, x2/y2 exclusive
//   clip_count_clr       synchronous clear of clip_count
//   clip_count           saturating count of draw pixels that were not written
// ---------------------------------------------------------------------------
module blit_addrgen_pipe #(
  parameter int ADDR_W  = 26,
  parameter int COORD_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic                clock,
  input  logic                resetn,
  blit_addrgen_pipe_if.slave  pix,
  input  logic [ADDR_W-1:0]   src_base,
  input  logic [ADDR_W-1:0]   dest_base,
  input  logic [COORD_W-1:0]  src_bpr,
  input  logic [COORD_W-1:0]  dest_bpr,
  input  logic [COORD_W-1:0]  clip_x1,
  input  logic [COORD_W-1:0]  clip_y1,
  input  logic [COORD_W-1:0]  clip_x2,
  input  logic [COORD_W-1:0]  clip_y2,
  input  logic                clip_count_clr,
  output logic [CNT_W-1:0]    clip_count
);
  localparam int PW = 2 * COORD_W;  // full row-product width
  localparam int XW = COORD_W + 2;  // x offset after scaling by up to 4 bytes

  // Byte lanes touched within a 32-bit word; reserved size writes nothing.
  function automatic logic [3:0] byte_en_f(input logic [1:0] ps, input logic [1:0] a);
    logic [3:0] be;
    case (ps)
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // S1 state
  logic              s1_valid_r;
  logic [PW-1:0]     src_prod_r, dest_prod_r;
  logic [XW-1:0]     sx_r, dx_r;
  logic [2:0]        src_bit_r;
  logic              wen_r, draw_r;
  logic [1:0]        pix_size_r;

  // S2 / output state
  logic              out_valid_r;
  logic [ADDR_W-1:0] out_src_addr_r, out_dest_addr_r;
  logic [2:0]        out_src_bit_r;
  logic              out_wen_r, out_clip_r;
  logic [3:0]        out_be_r;
  logic [CNT_W-1:0]  clip_count_r;

  logic              s2_adv_s, in_ready_s, fire_clip_s, inside_s, wen_s;
  logic [1:0]        shift_s;
  logic [XW-1:0]     sx_s, dx_s;
  logic [2:0]        src_bit_s;
  logic [ADDR_W-1:0] src_sum_s, dest_raw_s, dest_addr_s;
  logic [3:0]        be_s;

  // in_ready depends only on stage occupancy and out_ready, never on in_valid.
  assign s2_adv_s   = !out_valid_r || pix.out_ready;
  assign in_ready_s = !s1_valid_r || s2_adv_s;

  // S1 combinational: x scaling and clip test. Reserved size addresses as 8bpp.
  always_comb begin
    shift_s   = (pix.in_pix_size == 2'd3) ? 2'd0 : pix.in_pix_size;
    sx_s      = '0;
    src_bit_s = 3'd0;
    if (pix.in_textmode) begin
      sx_s      = XW'(pix.in_src_x >> 2'd3);
      src_bit_s = pix.in_src_x[2:0];
    end else begin
      sx_s      = XW'(pix.in_src_x) << shift_s;
      src_bit_s = 3'd0;
    end
    dx_s     = XW'(pix.in_dest_x) << shift_s;
    inside_s = (pix.in_dest_x >= clip_x1) && (pix.in_dest_x < clip_x2) &&
               (pix.in_dest_y >= clip_y1) && (pix.in_dest_y < clip_y2);
    wen_s    = pix.in_draw && inside_s && (pix.in_pix_size != 2'd3);
  end

  // S1 registers: load on accept, hold while stalled.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid_r  <= 1'b0;
      src_prod_r  <= '0;
      dest_prod_r <= '0;
      sx_r        <= '0;
      dx_r        <= '0;
      src_bit_r   <= 3'd0;
      wen_r       <= 1'b0;
      draw_r      <= 1'b0;
      pix_size_r  <= 2'd0;
    end else if (in_ready_s) begin
      s1_valid_r <= pix.in_valid;
      if (pix.in_valid) begin
        src_prod_r  <= PW'(pix.in_src_y) * PW'(src_bpr);
        dest_prod_r <= PW'(pix.in_dest_y) * PW'(dest_bpr);
        sx_r        <= sx_s;
        dx_r        <= dx_s;
        src_bit_r   <= src_bit_s;
        wen_r       <= wen_s;
        draw_r      <= pix.in_draw;
        pix_size_r  <= pix.in_pix_size;
      end
    end
  end

  // S2 combinational: address sums wrap modulo 2^ADDR_W, then align dest.
  always_comb begin
    src_sum_s  = src_base + ADDR_W'(src_prod_r) + ADDR_W'(sx_r);
    dest_raw_s = dest_base + ADDR_W'(dest_prod_r) + ADDR_W'(dx_r);
    case (pix_size_r)
      2'd1:    dest_addr_s = {dest_raw_s[ADDR_W-1:1], 1'b0};
      2'd2:    dest_addr_s = {dest_raw_s[ADDR_W-1:2], 2'b00};
      default: dest_addr_s = dest_raw_s;
    endcase
    if (wen_r) begin
      be_s = byte_en_f(pix_size_r, dest_addr_s[1:0]);
    end else begin
      be_s = 4'b0000;
    end
  end

  // S2 output registers: advance when empty or consumed, otherwise hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_r     <= 1'b0;
      out_src_addr_r  <= '0;
      out_dest_addr_r <= '0;
      out_src_bit_r   <= 3'd0;
      out_wen_r       <= 1'b0;
      out_be_r        <= 4'b0000;
      out_clip_r      <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r     <= s1_valid_r;
      out_src_addr_r  <= src_sum_s;
      out_dest_addr_r <= dest_addr_s;
      out_src_bit_r   <= src_bit_r;
      // Enables forced low for bubbles so an idle output never looks like a write.
      out_wen_r       <= s1_valid_r && wen_r;
      out_be_r        <= s1_valid_r ? be_s : 4'b0000;
      out_clip_r      <= s1_valid_r && draw_r && !wen_r;
    end
  end

  assign fire_clip_s = out_valid_r && pix.out_ready && out_clip_r;

  // Clipped-pixel counter: clear wins over a same-cycle increment.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clip_count_r <= '0;
    end else if (clip_count_clr) begin
      clip_count_r <= '0;
    end else if (fire_clip_s && (clip_count_r != {CNT_W{1'b1}})) begin
      clip_count_r <= clip_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign pix.in_ready      = in_ready_s;
  assign pix.out_valid     = out_valid_r;
  assign pix.out_src_addr  = out_src_addr_r;
  assign pix.out_dest_addr = out_dest_addr_r;
  assign pix.out_src_bit   = out_src_bit_r;
  assign pix.out_write_en  = out_wen_r;
  assign pix.out_byte_en   = out_be_r;
  assign clip_count        = clip_count_r;
endmodule

// File: tb/tb_blit_addrgen_pipe.sv
// ---------------------------------------------------------------------------
// tb_blit_addrgen_pipe
// Directed bench for blit_addrgen_pipe: address arithmetic, clipping, byte
// enables, latency, back-pressure, reset flush and counter saturation.
// Counter width is reduced to 4 bits so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_blit_addrgen_pipe;
  localparam int ADDR_W  = 26;
  localparam int COORD_W = 16;
  localparam int CNT_W   = 4;

  logic               clock;
  logic               resetn;
  logic [ADDR_W-1:0]  src_base, dest_base;
  logic [COORD_W-1:0] src_bpr, dest_bpr;
  logic [COORD_W-1:0] clip_x1, clip_y1, clip_x2, clip_y2;
  logic               clip_count_clr;
  logic [CNT_W-1:0]   clip_count;

  int checks_cnt = 0;
  int errors_cnt = 0;

  blit_addrgen_pipe_if #(.ADDR_W(ADDR_W), .COORD_W(COORD_W)) bus ();

  blit_addrgen_pipe #(.ADDR_W(ADDR_W), .COORD_W(COORD_W), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .pix            (bus.slave),
    .src_base       (src_base),
    .dest_base      (dest_base),
    .src_bpr        (src_bpr),
    .dest_bpr       (dest_bpr),
    .clip_x1        (clip_x1),
    .clip_y1        (clip_y1),
    .clip_x2        (clip_x2),
    .clip_y2        (clip_y2),
    .clip_count_clr (clip_count_clr),
    .clip_count     (clip_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_px(input logic [15:0] dx, input logic [15:0] dy,
                          input logic [15:0] sx, input logic [15:0] sy,
                          input logic draw, input logic text, input logic [1:0] ps);
    bus.in_dest_x   = dx;
    bus.in_dest_y   = dy;
    bus.in_src_x    = sx;
    bus.in_src_y    = sy;
    bus.in_draw     = draw;
    bus.in_textmode = text;
    bus.in_pix_size = ps;
  endtask

  // One pixel through an empty pipe: checks 2-cycle latency and the drain.
  task automatic xfer(input logic [15:0] dx, input logic [15:0] dy,
                      input logic [15:0] sx, input logic [15:0] sy,
                      input logic draw, input logic text, input logic [1:0] ps,
                      output logic [ADDR_W-1:0] o_src, output logic [ADDR_W-1:0] o_dest,
                      output logic [2:0] o_bit, output logic o_wen, output logic [3:0] o_be);
    @(negedge clock);
    drive_px(dx, dy, sx, sy, draw, text, ps);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("in_rdy", bus.in_ready, 1'b1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    chk("lat1", bus.out_valid, 1'b0);
    @(posedge clock);
    #1 chk("lat2", bus.out_valid, 1'b1);
    o_src  = bus.out_src_addr;
    o_dest = bus.out_dest_addr;
    o_bit  = bus.out_src_bit;
    o_wen  = bus.out_write_en;
    o_be   = bus.out_byte_en;
    @(posedge clock);
    #1 chk("drain", bus.out_valid, 1'b0);
  endtask

  logic [ADDR_W-1:0] g_src, g_dest, held_dest;
  logic [2:0]        g_bit;
  logic              g_wen, stalled;
  logic [3:0]        g_be, held_be;
  int                sent, recv;

  initial begin
    resetn = 1'b0;
    clip_count_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive_px(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 2'd0);
    src_base = 26'h200;  src_bpr = 16'd100;
    dest_base = 26'h100; dest_bpr = 16'd640;
    clip_x1 = 16'd0; clip_y1 = 16'd0; clip_x2 = 16'd640; clip_y2 = 16'd480;

    // Reset state
    #12;
    chk("rst_ov",  bus.out_valid, 1'b0);
    chk("rst_we",  bus.out_write_en, 1'b0);
    chk("rst_be",  bus.out_byte_en, 4'b0000);
    chk("rst_cc",  clip_count, 4'd0);
    chk("rst_dst", bus.out_dest_addr, 26'd0);
    @(negedge clock) resetn = 1'b1;

    // 8bpp draw inside window
    xfer(16'd3, 16'd2, 16'd3, 16'd1, 1'b1, 1'b0, 2'd0, g_src, g_dest, g_bit, g_wen, g_be);
    chk("t1_dst", g_dest, 26'h603);
    chk("t1_src", g_src, 26'h267);
    chk("t1_we",  g_wen, 1'b1);
    chk("t1_be",  g_be, 4'b1000);
    chk("t1_cc",  clip_count, 4'd0);

    // Textmode glyph source, address-only pixel
    src_base = 26'h0; src_bpr = 16'd16;
    xfer(16'd0, 16'd0, 16'd13, 16'd4, 1'b0, 1'b1, 2'd0, g_src, g_dest, g_bit, g_wen, g_be);
    chk("t2_src", g_src, 26'd65);
    chk("t2_bit", g_bit, 3'd5);
    chk("t2_we",  g_wen, 1'b0);
    chk("t2_cc",  clip_count, 4'd0);
    src_base = 26'h200; src_bpr = 16'd100;

    // 32bpp right clip edge
    clip_x2 = 16'd10;
    xfer(16'd10, 16'd0, 16'd2, 16'd0, 1'b1, 1'b0, 2'd2, g_src, g_dest, g_bit, g_wen, g_be);
    chk("t3a_we",  g_wen, 1'b0);
    chk("t3a_be",  g_be, 4'b0000);
    chk("t3a_dst", g_dest, 26'h128);
    chk("t3a_cc",  clip_count, 4'd1);
    xfer(16'd9, 16'd0, 16'd2, 16'd0, 1'b1, 1'b0, 2'd2, g_src, g_dest, g_bit, g_wen, g_be);
    chk("t3b_we",  g_wen, 1'b1);
    chk("t3b_be",  g_be, 4'b1111);
    chk("t3b_dst", g_dest, 26'h124);
    chk("t3b_src", g_src, 26'h208);
    chk("t3b_cc",  clip_count, 4'd1);
    clip_x2 = 16'd640;

    // 16bpp with odd base: bit 0 forced low, upper halfword lanes
    dest_base = 26'h101;
    xfer(16'd5, 16'd1, 16'd0, 16'd0, 1'b1, 1'b0, 2'd1, g_src, g_dest, g_bit, g_wen, g_be);
    chk("t4_dst", g_dest, 26'h38A);
    chk("t4_be",  g_be, 4'b1100);
    dest_base = 26'h100;

    // Reserved pixel size: 8bpp addressing, never written, counted
    xfer(16'd3, 16'd2, 16'd0, 16'd0, 1'b1, 1'b0, 2'd3, g_src, g_dest, g_bit, g_wen, g_be);
    chk("t5_dst", g_dest, 26'h603);
    chk("t5_we",  g_wen, 1'b0);
    chk("t5_be",  g_be, 4'b0000);
    chk("t5_cc",  clip_count, 4'd2);

    // Empty window (x1 == x2)
    clip_x1 = 16'd5; clip_x2 = 16'd5;
    xfer(16'd5, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, g_src, g_dest, g_bit, g_wen, g_be);
    chk("t6_we",  g_wen, 1'b0);
    chk("t6_dst", g_dest, 26'h105);
    chk("t6_cc",  clip_count, 4'd3);
    clip_x1 = 16'd0; clip_x2 = 16'd640;

    // Standalone clear
    @(negedge clock) clip_count_clr = 1'b1;
    @(negedge clock) clip_count_clr = 1'b0;
    chk("clr_cc", clip_count, 4'd0);

    // Stream of 8 with back-pressure in cycles 3..5
    dest_base = 26'h0;
    sent = 0; recv = 0; stalled = 1'b0; held_dest = '0; held_be = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 8) begin
        drive_px(16'(sent), 16'd1, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        chk("stl_ov",  bus.out_valid, 1'b1);
        chk("stl_dst", bus.out_dest_addr, held_dest);
        chk("stl_be",  bus.out_byte_en, held_be);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (recv < 8) begin
          chk("str_dst", bus.out_dest_addr, 26'(640 + recv));
          chk("str_be",  bus.out_byte_en, 4'b0001 << (recv % 4));
        end
        recv++;
      end
      stalled   = bus.out_valid && !bus.out_ready;
      held_dest = bus.out_dest_addr;
      held_be   = bus.out_byte_en;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("str_recv", 64'(recv), 64'd8);
    chk("str_cc", clip_count, 4'd0);
    dest_base = 26'h100;

    // Reset with both stages full
    xfer(16'd700, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, g_src, g_dest, g_bit, g_wen, g_be);
    chk("pre_cc", clip_count, 4'd1);
    @(negedge clock);
    bus.out_ready = 1'b0;
    drive_px(16'd1, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0);
    bus.in_valid = 1'b1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("full_ov", bus.out_valid, 1'b1);
    chk("full_ir", bus.in_ready, 1'b0);
    resetn = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("ar_ov", bus.out_valid, 1'b0);
    chk("ar_we", bus.out_write_en, 1'b0);
    chk("ar_cc", clip_count, 4'd0);
    @(negedge clock) resetn = 1'b1;
    bus.out_ready = 1'b1;
    #1 chk("rel_ir", bus.in_ready, 1'b1);
    xfer(16'd3, 16'd2, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, g_src, g_dest, g_bit, g_wen, g_be);
    chk("rel_dst", g_dest, 26'h603);
    chk("rel_be",  g_be, 4'b1000);

    // Saturation of a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      xfer(16'd700, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0, g_src, g_dest, g_bit, g_wen, g_be);
      if (i == 14) chk("sat15", clip_count, 4'hF);
    end
    chk("sat_hold", clip_count, 4'hF);

    // Clear in the same cycle as a clipped handshake
    @(negedge clock);
    drive_px(16'd700, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 2'd0);
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(posedge clock);
    #1 chk("cs_ov", bus.out_valid, 1'b1);
    clip_count_clr = 1'b1;
    @(posedge clock);
    #1 clip_count_clr = 1'b0;
    chk("cs_cc", clip_count, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
